// File: rtl/intr_arbiter_if.sv
// Device-side and Unibus-side signal bundle for intr_arbiter.
// master: the arbiter. slave: the device models and Unibus pin drivers.
interface intr_arbiter_if #(
   parameter int NDEV = 8
);
   logic [NDEV-1:0]   dev_intreq;
   logic [8*NDEV-1:0] dev_irvec;
   logic [2*NDEV-1:0] dev_level;
   logic              intgnt;
   logic [7:0]        igvec;
   logic              init_in_h;
   logic [3:0]        bg_in_h;
   logic              bbsy_in_h;
   logic              sack_in_h;
   logic              ssyn_in_h;
   logic [3:0]        br_out_h;
   logic [3:0]        bg_out_h;
   logic              sack_out_h;
   logic              bbsy_out_h;
   logic              intr_out_h;
   logic [15:0]       d_out_h;

   modport master (
      input  dev_intreq, dev_irvec, dev_level,
      input  init_in_h, bg_in_h, bbsy_in_h, sack_in_h, ssyn_in_h,
      output intgnt, igvec,
      output br_out_h, bg_out_h, sack_out_h, bbsy_out_h, intr_out_h, d_out_h
   );

   modport slave (
      output dev_intreq, dev_irvec, dev_level,
      output init_in_h, bg_in_h, bbsy_in_h, sack_in_h, ssyn_in_h,
      input  intgnt, igvec,
      input  br_out_h, bg_out_h, sack_out_h, bbsy_out_h, intr_out_h, d_out_h
   );
endinterface

// File: rtl/intr_arbiter.sv
// Unibus interrupt sequencer for the internal PDP-11 device models.
// Raises BR for the highest pending level, runs the BG/SACK/BBSY/INTR/SSYN
// handshake and broadcasts a one-cycle intgnt/igvec to the devices.
// Optional build macro INTR_ARB_STATS_EN adds grant/timeout counters on the
// status read page selected by armwdata[0].
// Status word bit 27 (top bit of the state field) is the sticky timeout flag;
// the FSM itself only needs three state bits.
module intr_arbiter #(
   parameter int NDEV    = 8,
   parameter int TIMEOUT = 1000,
   parameter int SETTLE  = 15
) (
   input  logic          CLOCK,
   input  logic          RESET,
   input  logic          armwrite,
   input  logic          armraddr,
   input  logic          armwaddr,
   input  logic [31:0]   armwdata,
   output logic [31:0]   armrdata,
   intr_arbiter_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ     = 3'd1,
      S_WAITBUS = 3'd2,
      S_INTR    = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t      state_q, state_n;
   logic        enable_q;
   logic        tmo_sticky_q;
   logic [1:0]  lvl_q, lvl_n;
   logic [5:0]  win_q, win_n;
   logic [7:0]  vec_q, vec_n;
   logic [15:0] cnt_q, cnt_n;
   logic [3:0]  br_q, br_n;
   logic        sack_q, sack_n;
   logic        bbsy_q, bbsy_n;
   logic        intr_q, intr_n;
   logic        gnt_q, gnt_n;
   logic        tmo_set;

   logic [3:0]  lvl_pend;
   logic        any_req;
   logic [1:0]  live_lvl;
   logic [5:0]  pick_idx;
   logic [7:0]  pick_vec;
   logic [3:0]  bg_block;
   logic        drive_ok;
   logic        ctl_write;
   logic [31:0] status_word;

   assign ctl_write = armwrite & armwaddr;
   assign drive_ok  = enable_q & ~bus.init_in_h;

   // Collect which BR levels currently have at least one requester.
   always_comb begin
      lvl_pend = '0;
      for (int i = 0; i < NDEV; i++)
         if (bus.dev_intreq[i]) lvl_pend[bus.dev_level[2*i +: 2]] = 1'b1;
   end

   assign any_req = |lvl_pend;

   // Highest pending level wins.
   always_comb begin
      live_lvl = 2'd0;
      for (int l = 0; l < 4; l++)
         if (lvl_pend[l]) live_lvl = 2'(l);
   end

   // Lowest device index at the winning level (scan downward, last hit wins).
   always_comb begin
      pick_idx = '0;
      pick_vec = '0;
      for (int i = NDEV - 1; i >= 0; i--)
         if (bus.dev_intreq[i] && (bus.dev_level[2*i +: 2] == live_lvl)) begin
            pick_idx = 6'(i);
            pick_vec = bus.dev_irvec[8*i +: 8];
         end
   end

   // Next-state and registered-output logic; INIT or disable aborts to IDLE.
   always_comb begin
      state_n = state_q;
      lvl_n   = lvl_q;
      win_n   = win_q;
      vec_n   = vec_q;
      cnt_n   = cnt_q;
      br_n    = '0;
      sack_n  = 1'b0;
      bbsy_n  = 1'b0;
      intr_n  = 1'b0;
      gnt_n   = 1'b0;
      tmo_set = 1'b0;
      if (!drive_ok) begin
         state_n = S_IDLE;
         lvl_n   = '0;
         win_n   = '0;
         vec_n   = '0;
         cnt_n   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (any_req) begin
                  br_n    = 4'b0001 << live_lvl;
                  state_n = S_REQ;
               end
            end
            S_REQ: begin
               if (!any_req) begin
                  state_n = S_IDLE;
               end else if (bus.bg_in_h[live_lvl]) begin
                  lvl_n   = live_lvl;
                  win_n   = pick_idx;
                  vec_n   = pick_vec;
                  cnt_n   = '0;
                  sack_n  = 1'b1;
                  state_n = S_WAITBUS;
               end else begin
                  br_n = 4'b0001 << live_lvl;
               end
            end
            S_WAITBUS: begin
               sack_n = 1'b1;
               if (!bus.bg_in_h[lvl_q] && !bus.bbsy_in_h && !bus.ssyn_in_h) begin
                  if (cnt_q == 16'(SETTLE - 1)) begin
                     sack_n  = 1'b0;
                     bbsy_n  = 1'b1;
                     intr_n  = 1'b1;
                     cnt_n   = '0;
                     state_n = S_INTR;
                  end else begin
                     cnt_n = cnt_q + 16'd1;
                  end
               end else begin
                  cnt_n = '0;
               end
            end
            S_INTR: begin
               if (bus.ssyn_in_h) begin
                  gnt_n   = 1'b1;
                  state_n = S_DONE;
               end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                  tmo_set = 1'b1;
                  state_n = S_DONE;
               end else begin
                  cnt_n  = cnt_q + 16'd1;
                  bbsy_n = 1'b1;
                  intr_n = 1'b1;
               end
            end
            S_DONE: begin
               if (!bus.ssyn_in_h) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   // State register, latched winner, enable and sticky timeout flag.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q      <= S_IDLE;
         enable_q     <= 1'b0;
         tmo_sticky_q <= 1'b0;
         lvl_q        <= '0;
         win_q        <= '0;
         vec_q        <= '0;
         cnt_q        <= '0;
         br_q         <= '0;
         sack_q       <= 1'b0;
         bbsy_q       <= 1'b0;
         intr_q       <= 1'b0;
         gnt_q        <= 1'b0;
      end else begin
         state_q <= state_n;
         lvl_q   <= lvl_n;
         win_q   <= win_n;
         vec_q   <= vec_n;
         cnt_q   <= cnt_n;
         br_q    <= br_n;
         sack_q  <= sack_n;
         bbsy_q  <= bbsy_n;
         intr_q  <= intr_n;
         gnt_q   <= gnt_n;
         if (ctl_write) enable_q <= armwdata[31];
         if (tmo_set) tmo_sticky_q <= 1'b1;
      end
   end

   // Grant we hold (or are taking this cycle) is not passed downstream.
   always_comb begin
      bg_block = '0;
      if (drive_ok) begin
         case (state_q)
            S_REQ:             if (any_req) bg_block[live_lvl] = 1'b1;
            S_WAITBUS, S_INTR: bg_block[lvl_q] = 1'b1;
            default:           bg_block = '0;
         endcase
      end
   end

   assign bus.bg_out_h   = bus.bg_in_h & ~bg_block;
   assign bus.br_out_h   = drive_ok ? br_q : 4'b0000;
   assign bus.sack_out_h = drive_ok & sack_q;
   assign bus.bbsy_out_h = drive_ok & bbsy_q;
   assign bus.intr_out_h = drive_ok & intr_q;
   assign bus.d_out_h    = (drive_ok && intr_q) ? {8'h00, vec_q} : 16'h0000;
   assign bus.intgnt     = drive_ok & gnt_q;
   assign bus.igvec      = (drive_ok && gnt_q) ? vec_q : 8'h00;

   assign status_word = {enable_q, 3'b000, tmo_sticky_q, state_q, lvl_q, win_q,
                         8'h00, vec_q};

`ifdef INTR_ARB_STATS_EN
   logic [15:0] gcnt_q;
   logic [7:0]  tcnt_q;
   logic        unused_bits;

   // Saturating grant and timeout counters, cleared by RESET or control write bit 1.
   always_ff @(posedge CLOCK) begin
      if (RESET || (ctl_write && armwdata[1])) begin
         gcnt_q <= '0;
         tcnt_q <= '0;
      end else begin
         if (gnt_n && (gcnt_q != 16'hFFFF)) gcnt_q <= gcnt_q + 16'd1;
         if (tmo_set && (tcnt_q != 8'hFF)) tcnt_q <= tcnt_q + 8'd1;
      end
   end

   assign armrdata = !armraddr   ? 32'h4941_0003 :
                     armwdata[0] ? {tcnt_q, 8'h00, gcnt_q} : status_word;
   assign unused_bits = ^{armwdata[30:2], bus.sack_in_h};
`else
   logic unused_bits;

   assign armrdata    = armraddr ? status_word : 32'h4941_0003;
   assign unused_bits = ^{armwdata[30:0], bus.sack_in_h};
`endif

endmodule

// File: tb/tb_intr_arbiter.sv
// Self-checking bench for intr_arbiter: directed table, hand-written
// handshake sequences and randomized request sets against a priority model.
`timescale 1ns/1ps
module tb_intr_arbiter;
   localparam int NDEV    = 8;
   localparam int TIMEOUT = 1000;
   localparam int SETTLE  = 15;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic        armwrite = 1'b0;
   logic        armraddr = 1'b1;
   logic        armwaddr = 1'b0;
   logic [31:0] armwdata = 32'h0;
   logic [31:0] armrdata;

   intr_arbiter_if #(.NDEV(NDEV)) bus();

   intr_arbiter #(.NDEV(NDEV), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .armwrite(armwrite), .armraddr(armraddr),
      .armwaddr(armwaddr), .armwdata(armwdata), .armrdata(armrdata), .bus(bus)
   );

   always #5 CLOCK = ~CLOCK;

   int errors = 0;
   int checks = 0;
   int gnt_seen = 0;

   always @(negedge CLOCK) if (bus.intgnt === 1'b1) gnt_seen++;

   typedef struct {
      bit         en;
      logic [7:0]  req;
      logic [15:0] lvl;
      logic [3:0]  bg;
      logic [3:0]  exp_br;
      logic [3:0]  exp_bgo;
      bit         exp_sack;
   } vec_t;

   vec_t tbl[7];

   int         mdl_lvl[NDEV];
   logic [7:0] mdl_vec[NDEV];
   bit         mdl_req[NDEV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge CLOCK);
         #1;
      end
   endtask

   task automatic set_enable(input bit en);
      armwaddr = 1'b1;
      armwdata = {en, 31'h0};
      armwrite = 1'b1;
      step();
      armwrite = 1'b0;
      armwdata = 32'h0;
   endtask

   task automatic set_dev(input int i, input int lvl, input logic [7:0] vec);
      bus.dev_level[2*i +: 2] = 2'(lvl);
      bus.dev_irvec[8*i +: 8] = vec;
      bus.dev_intreq[i]       = 1'b1;
   endtask

   // Full master-side handshake; expects level lvl, vector vec from device win.
   task automatic run_txn(input int lvl, input logic [7:0] vec, input int win, input bit withdraw);
      int n;
      bit ok;
      ok = 1'b0;
      for (n = 0; n < 20; n++) begin
         if (bus.br_out_h != 4'b0000) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (!ok) begin
         bound_fail("br_wait");
         return;
      end
      chk("br_level", 32'(bus.br_out_h), 32'(4'b0001 << lvl));
      bus.bg_in_h = 4'(1 << lvl);
      #1;
      chk("bg_blocked", 32'(bus.bg_out_h), 32'h0);
      step();
      chk("sack_br", 32'({bus.sack_out_h, bus.br_out_h}), 32'h10);
      chk("status_latch", {16'h0, armrdata[23:16], armrdata[7:0]},
          {16'h0, 2'(lvl), 6'(win), vec});
      bus.bg_in_h = 4'b0000;
      if (withdraw) bus.dev_intreq[win] = 1'b0;
      ok = 1'b0;
      for (n = 1; n <= SETTLE + 10; n++) begin
         step();
         if (bus.intr_out_h) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         bound_fail("intr_wait");
         return;
      end
      chk("settle_cycles", 32'(n), 32'(SETTLE));
      chk("intr_drive", 32'({bus.sack_out_h, bus.bbsy_out_h, bus.d_out_h}),
          32'({1'b0, 1'b1, 8'h00, vec}));
      bus.ssyn_in_h = 1'b1;
      step();
      chk("grant", 32'({bus.intgnt, bus.igvec, bus.intr_out_h, bus.bbsy_out_h, bus.d_out_h}),
          32'({1'b1, vec, 1'b0, 1'b0, 16'h0000}));
      bus.dev_intreq[win] = 1'b0;
      step();
      chk("grant_one_cycle", 32'(bus.intgnt), 32'h0);
      bus.ssyn_in_h = 1'b0;
      step();
   endtask

   // Drive a single pending request through to the INTR state.
   task automatic to_intr(input int lvl, output bit ok);
      int n;
      ok = 1'b0;
      for (n = 0; n < 20; n++) begin
         if (bus.br_out_h != 4'b0000) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (!ok) return;
      bus.bg_in_h = 4'(1 << lvl);
      step();
      bus.bg_in_h = 4'b0000;
      ok = 1'b0;
      for (n = 0; n < SETTLE + 10; n++) begin
         step();
         if (bus.intr_out_h) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int n, g0, best;
      bit ok;

      tbl[0] = '{1'b1, 8'h04, 16'h0010, 4'b0000, 4'b0010, 4'b0000, 1'b0};
      tbl[1] = '{1'b1, 8'h04, 16'h0010, 4'b1000, 4'b0010, 4'b1000, 1'b0};
      tbl[2] = '{1'b1, 8'h04, 16'h0010, 4'b0010, 4'b0010, 4'b0000, 1'b1};
      tbl[3] = '{1'b0, 8'h04, 16'h0010, 4'b0010, 4'b0000, 4'b0010, 1'b0};
      tbl[4] = '{1'b1, 8'h21, 16'h0800, 4'b0001, 4'b0100, 4'b0001, 1'b0};
      tbl[5] = '{1'b1, 8'h00, 16'h0000, 4'b1111, 4'b0000, 4'b1111, 1'b0};
      tbl[6] = '{1'b1, 8'h04, 16'h0010, 4'b0001, 4'b0010, 4'b0001, 1'b0};

      bus.dev_intreq = '0;
      bus.dev_irvec  = '0;
      bus.dev_level  = '0;
      bus.init_in_h  = 1'b0;
      bus.bg_in_h    = 4'b0000;
      bus.bbsy_in_h  = 1'b0;
      bus.sack_in_h  = 1'b0;
      bus.ssyn_in_h  = 1'b0;

      step(3);
      RESET = 1'b0;
      step();

      armraddr = 1'b0;
      #1;
      chk("id_word", armrdata, 32'h4941_0003);
      armraddr = 1'b1;
      #1;
      chk("reset_status", armrdata, 32'h0);
      chk("reset_drives", 32'({bus.br_out_h, bus.sack_out_h, bus.bbsy_out_h, bus.intr_out_h,
                               bus.intgnt, bus.igvec, bus.d_out_h}), 32'h0);

      set_enable(1'b1);
      chk("enable_bit", 32'(armrdata[31]), 32'h1);

      // Single BR5 device, vector 060.
      set_dev(2, 1, 8'o060);
      run_txn(1, 8'o060, 2, 1'b0);

      // BR6 beats BR4.
      set_dev(0, 0, 8'o100);
      set_dev(5, 2, 8'o070);
      run_txn(2, 8'o070, 5, 1'b0);
      run_txn(0, 8'o100, 0, 1'b0);

      // Same level: lower index first.
      set_dev(1, 2, 8'o120);
      set_dev(3, 2, 8'o124);
      run_txn(2, 8'o120, 1, 1'b0);
      run_txn(2, 8'o124, 3, 1'b0);

      // Winner withdraws after SACK: latched vector still delivered.
      set_dev(4, 3, 8'o244);
      run_txn(3, 8'o244, 4, 1'b1);
      step(2);
      chk("idle_after_txns", 32'(armrdata[26:24]), 32'h0);

      // Directed table: BR drive, BG pass-through/blocking, SACK.
      set_enable(1'b0);
      step();
      for (int r = 0; r < 7; r++) begin
         bus.dev_intreq = tbl[r].req;
         bus.dev_level  = tbl[r].lvl;
         bus.bg_in_h    = 4'b0000;
         set_enable(tbl[r].en);
         step();
         chk($sformatf("tbl%0d_br", r), 32'(bus.br_out_h), 32'(tbl[r].exp_br));
         bus.bg_in_h = tbl[r].bg;
         #1;
         chk($sformatf("tbl%0d_bgout", r), 32'(bus.bg_out_h), 32'(tbl[r].exp_bgo));
         step();
         chk($sformatf("tbl%0d_sack", r), 32'(bus.sack_out_h), 32'(tbl[r].exp_sack));
         bus.bg_in_h    = 4'b0000;
         bus.dev_intreq = '0;
         set_enable(1'b0);
         step();
      end

      // Random request sets against the priority model.
      set_enable(1'b1);
      step();
      for (int it = 0; it < 15; it++) begin
         for (int i = 0; i < NDEV; i++) begin
            mdl_lvl[i] = int'($urandom_range(0, 3));
            mdl_vec[i] = 8'($urandom);
            mdl_req[i] = ($urandom_range(0, 1) == 1);
            bus.dev_level[2*i +: 2] = 2'(mdl_lvl[i]);
            bus.dev_irvec[8*i +: 8] = mdl_vec[i];
         end
         mdl_req[it % NDEV] = 1'b1;
         for (int i = 0; i < NDEV; i++) bus.dev_intreq[i] = mdl_req[i];
         for (int k = 0; k < NDEV; k++) begin
            best = -1;
            for (int i = 0; i < NDEV; i++)
               if (mdl_req[i] && (best < 0 || mdl_lvl[i] > mdl_lvl[best])) best = i;
            if (best < 0) break;
            run_txn(mdl_lvl[best], mdl_vec[best], best, 1'b0);
            mdl_req[best] = 1'b0;
         end
         bus.dev_intreq = '0;
         bus.bg_in_h    = 4'b0000;
         bus.ssyn_in_h  = 1'b0;
         set_enable(1'b0);
         set_enable(1'b1);
         step();
      end

      // No SSYN: abort after TIMEOUT cycles in INTR.
      set_dev(2, 1, 8'o060);
      to_intr(1, ok);
      if (!ok) begin
         bound_fail("timeout_setup");
      end else begin
         g0 = gnt_seen;
         n = 0;
         while (bus.intr_out_h && n < TIMEOUT + 200) begin
            step();
            n++;
         end
         chk("timeout_cycles", 32'(n), 32'(TIMEOUT));
         chk("timeout_drives", 32'({bus.intr_out_h, bus.bbsy_out_h, bus.d_out_h}), 32'h0);
         chk("timeout_no_gnt", 32'(gnt_seen - g0), 32'h0);
         chk("timeout_sticky", 32'(armrdata[27]), 32'h1);
      end
      bus.dev_intreq = '0;
      step(3);

      // INIT during INTR: drives drop at once, back to IDLE, no grant.
      set_dev(6, 3, 8'o300);
      to_intr(3, ok);
      if (!ok) begin
         bound_fail("init_setup");
      end else begin
         g0 = gnt_seen;
         bus.init_in_h = 1'b1;
         #1;
         chk("init_drives", 32'({bus.br_out_h, bus.sack_out_h, bus.bbsy_out_h, bus.intr_out_h,
                                 bus.d_out_h}), 32'h0);
         bus.ssyn_in_h = 1'b1;
         step();
         chk("init_state", 32'(armrdata[26:24]), 32'h0);
         step();
         chk("init_no_gnt", 32'(gnt_seen - g0), 32'h0);
         chk("init_keeps_enable", 32'(armrdata[31]), 32'h1);
         bus.ssyn_in_h  = 1'b0;
         bus.dev_intreq = '0;
         bus.init_in_h  = 1'b0;
         step(2);
      end

      // RESET clears enable and the sticky timeout flag.
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      #1;
      chk("reset_again_status", armrdata, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1);
   end
endmodule
